// File: rtl/queue_pkg.sv
// Shared definitions for the stack/queue buffering blocks: default widths,
// depth derivation and the request decode used by the queue control logic.
package queue_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_BITS  = 8;

    // Number of entries addressed by an addr_bits-wide pointer
    function automatic int depth_of(input int addr_bits);
        return 1 << addr_bits;
    endfunction

    // Occupancy needs one more bit than the pointers so that DEPTH is representable
    function automatic int count_width_of(input int addr_bits);
        return addr_bits + 1;
    endfunction

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/queue_if.sv
// Producer/consumer handshake bundle for the queue: the request side drives
// data and enq/deq, the queue side returns data, status and error flags.
interface queue_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  enq;
    logic                  deq;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  overflow;
    logic                  underflow;
    logic                  empty;
    logic                  full;
    logic [ADDR_BITS:0]    count_out;

    modport master (
        output data_in, enq, deq,
        input  data_out, overflow, underflow, empty, full, count_out
    );

    modport slave (
        input  data_in, enq, deq,
        output data_out, overflow, underflow, empty, full, count_out
    );
endinterface

// File: rtl/queue_mem.sv
// Storage array for the queue: synchronous write, asynchronous read, so the
// read of a slot in the same cycle as its overwrite returns the old word.
module queue_mem
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input  logic                  clk,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = depth_of(ADDR_BITS);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/queue.sv
// Circular FIFO: head/tail pointers wrap naturally, occupancy held in count_reg,
// empty/full decoded from it; sticky overflow/underflow report rejected requests.
module queue
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_BITS  = DEFAULT_ADDR_BITS
) (
    input logic   clk,
    input logic   rst,
    queue_if.slave bus
);
    localparam int              DEPTH       = depth_of(ADDR_BITS);
    localparam int              CW          = count_width_of(ADDR_BITS);
    localparam logic [CW-1:0]   DEPTH_COUNT = CW'(DEPTH);

    logic [ADDR_BITS-1:0]  head_reg, tail_reg;
    logic [CW-1:0]         count_reg, count_next;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic                  overflow_reg, underflow_reg;
    logic                  empty_w, full_w;
    logic                  accept_enq, accept_deq;
    logic [DATA_WIDTH-1:0] rd_data;
    op_e                   op;

    assign empty_w = (count_reg == '0);
    assign full_w  = (count_reg == DEPTH_COUNT);
    assign op      = op_e'({bus.enq, bus.deq});

    // At full a paired dequeue frees the slot being written; at empty the
    // paired dequeue is rejected because there is no bypass path.
    always_comb begin
        accept_enq = 1'b0;
        accept_deq = 1'b0;
        case (op)
            OP_ENQ:  accept_enq = !full_w;
            OP_DEQ:  accept_deq = !empty_w;
            OP_BOTH: begin
                accept_enq = 1'b1;
                accept_deq = !empty_w;
            end
            default: ;
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({accept_enq, accept_deq})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (accept_enq) begin
                tail_reg <= tail_reg + ADDR_BITS'(1);
            end
            if (accept_deq) begin
                head_reg     <= head_reg + ADDR_BITS'(1);
                data_out_reg <= rd_data;
            end
            if (bus.enq) begin
                overflow_reg <= !accept_enq;
            end
            if (bus.deq) begin
                underflow_reg <= !accept_deq;
            end
        end
    end

    queue_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .wr_addr (tail_reg),
        .wr_data (bus.data_in),
        .wr_en   (accept_enq),
        .rd_addr (head_reg),
        .rd_data (rd_data)
    );

    assign bus.data_out  = data_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count_out = count_reg;

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue (DEPTH 4): a reference queue of accepted words
// is pushed on accepted enqueues and popped against data_out on accepted dequeues.
module tb_queue;

    localparam int DW    = 8;
    localparam int AB    = 2;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    queue_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) qif ();

    queue #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] m_out;
    logic          m_ovf;
    logic          m_unf;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ".data_out"},  32'(qif.data_out),  32'(m_out));
        check_val({tag, ".count"},     32'(qif.count_out), 32'(sb.size()));
        check_val({tag, ".full"},      32'(qif.full),      32'(sb.size() == DEPTH));
        check_val({tag, ".empty"},     32'(qif.empty),     32'(sb.size() == 0));
        check_val({tag, ".overflow"},  32'(qif.overflow),  32'(m_ovf));
        check_val({tag, ".underflow"}, 32'(qif.underflow), 32'(m_unf));
    endtask

    task automatic model_reset();
        sb.delete();
        m_out = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Drive one cycle of requests, then update the reference model and compare
    task automatic do_op(input logic e, input logic d, input logic [DW-1:0] din, input string tag);
        logic acc_e, acc_d;
        acc_d = d && (sb.size() > 0);
        acc_e = e && ((sb.size() < DEPTH) || d);
        qif.enq     = e;
        qif.deq     = d;
        qif.data_in = din;
        @(posedge clk);
        #1;
        if (acc_d) m_out = sb.pop_front();
        if (acc_e) sb.push_back(din);
        if (e) m_ovf = !acc_e;
        if (d) m_unf = !acc_d;
        qif.enq = 1'b0;
        qif.deq = 1'b0;
        $display("%s: enq=%0b deq=%0b din=%02h -> dout=%02h cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b",
                 tag, e, d, din, qif.data_out, qif.count_out, qif.full, qif.empty,
                 qif.overflow, qif.underflow);
        check_state(tag);
    endtask

    initial begin
        rst         = 1'b1;
        qif.enq     = 1'b0;
        qif.deq     = 1'b0;
        qif.data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b0;

        // Fill, overflow, drain, underflow, then flag clearing
        do_op(1, 0, 8'h11, "fill");
        do_op(1, 0, 8'h22, "fill");
        do_op(1, 0, 8'h33, "fill");
        do_op(1, 0, 8'h44, "fill");
        do_op(1, 0, 8'h55, "overflow");
        for (int i = 0; i < 4; i++) do_op(0, 1, 8'h00, "drain");
        do_op(0, 1, 8'h00, "underflow");
        do_op(1, 0, 8'h01, "ovf_clear");
        do_op(0, 1, 8'h00, "unf_clear");

        // Wrap-around
        for (int i = 0; i < 3; i++) do_op(1, 0, 8'(8'hB0 + i), "wrap_enq");
        for (int i = 0; i < 3; i++) do_op(0, 1, 8'h00, "wrap_deq");
        for (int i = 0; i < 4; i++) do_op(1, 0, 8'(8'hA0 + i), "wrap_fill");
        for (int i = 0; i < 4; i++) do_op(0, 1, 8'h00, "wrap_drain");

        // Simultaneous at full
        do_op(1, 0, 8'h11, "sf_fill");
        do_op(1, 0, 8'h22, "sf_fill");
        do_op(1, 0, 8'h33, "sf_fill");
        do_op(1, 0, 8'h44, "sf_fill");
        do_op(1, 1, 8'h99, "both_full");
        for (int i = 0; i < 4; i++) do_op(0, 1, 8'h00, "sf_drain");

        // Simultaneous at empty
        do_op(1, 1, 8'h77, "both_empty");
        do_op(0, 1, 8'h00, "be_deq");

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "rand");
        end

        // Asynchronous reset mid-stream with count=3, overflow set, data_out nonzero
        while (sb.size() > 0) do_op(0, 1, 8'h00, "pre_drain");
        do_op(1, 0, 8'hC1, "pre_rst");
        do_op(1, 0, 8'hC2, "pre_rst");
        do_op(1, 0, 8'hC3, "pre_rst");
        do_op(1, 0, 8'hC4, "pre_rst");
        do_op(1, 0, 8'hC5, "pre_rst");
        do_op(0, 1, 8'h00, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        $display("async_rst: dout=%02h cnt=%0d empty=%0b", qif.data_out, qif.count_out, qif.empty);
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;
        do_op(1, 0, 8'hD0, "post_rst");
        do_op(0, 1, 8'h00, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/queue.md
# queue

Circular FIFO queue for `DATA_WIDTH`-bit words with `2**ADDR_BITS` entries. Words are written at the tail and read from the head, the opposite end from the push/pop LIFO discipline. It is the buffering block between a producer and a consumer in the datapath. It reports occupancy, full/empty status, and sticky overflow/underflow error flags.

## Interface
- `DATA_WIDTH`, 8, word width in bits
- `ADDR_BITS`, 8, address width; `DEPTH = 2**ADDR_BITS` entries
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `data_in` in `DATA_WIDTH`: word to enqueue
- `enq` in 1: enqueue request, sampled at the rising edge
- `deq` in 1: dequeue request, sampled at the rising edge
- `data_out` out `DATA_WIDTH`: last dequeued word (registered)
- `overflow` out 1: sticky; an enqueue was rejected because the queue was full
- `underflow` out 1: sticky; a dequeue was rejected because the queue was empty
- `empty` out 1: `count == 0`
- `full` out 1: `count == DEPTH`
- `count_out` out `ADDR_BITS+1`: current occupancy, 0..DEPTH

## Operation
- State registers:
  - `head` (ADDR_BITS bits): read pointer
  - `tail` (ADDR_BITS bits): write pointer
  - `count` (ADDR_BITS+1 bits)
  - `data_out`, `overflow`, `underflow`
- Pointers wrap modulo DEPTH through natural ADDR_BITS-bit overflow. `count` never wraps.
- `enq` only:
  - Not full: write `data_in` to `mem[tail]`, `tail+1`, `count+1`, clear `overflow`.
  - Full: no write, no pointer change, set `overflow`.
- `deq` only:
  - Not empty: `data_out <= mem[head]`, `head+1`, `count-1`, clear `underflow`.
  - Empty: `data_out` holds, set `underflow`.
- `enq` and `deq` together:
  - Neither full nor empty: both performed, `count` unchanged, both flags cleared.
  - Full: both performed. The read returns the old `mem[head]` before the write to the same slot (`tail == head`). `count` stays DEPTH. Both flags cleared.
  - Empty: enqueue performed, dequeue rejected, `underflow` set, `count` becomes 1. There is no write-through bypass.
- Neither asserted: all state holds, including the sticky flags.
- Sticky flags clear only on reset or on a later accepted operation of the same kind: `overflow` on an accepted enqueue, `underflow` on an accepted dequeue.
- `empty`, `full` and `count_out` decode combinationally from the `count` register, so they are glitch-free with respect to the inputs.

## Timing
- Reset values: `head = tail = 0`, `count = 0`, `data_out = 0`, `overflow = 0`, `underflow = 0`. Therefore `empty = 1`, `full = 0`, `count_out = 0`.
- Reset asserted mid-operation: all state clears immediately, independent of `clk`. Memory contents are not cleared and are unreachable until rewritten.
- Dequeue latency: the dequeued word is on `data_out` right after the accepting edge. It holds until the next accepted dequeue.
- Enqueue-to-dequeue: a word enqueued at edge N can be dequeued at edge N+1 at the earliest.
- `count_out`, `empty`, `full` and the flags update at the same edge as the operation that changes them.
- Throughput: one enqueue and one dequeue per cycle sustained, with no bubbles.

## Structure
- Shared header holds `DEPTH` derivation and the pointer/count width localparams, reused by the stack and queue blocks.
- One sub-module, `queue_mem`:
  - DEPTH × DATA_WIDTH register array
  - synchronous write port: `wr_addr`, `wr_data`, `wr_en`
  - asynchronous read port: `rd_addr`, `rd_data`
- Pointer, count and flag logic live in `queue`. There is no separate FSM; the state is `count`, with empty and full as decoded boundary states.

## Test plan
All scenarios use `ADDR_BITS=2` (DEPTH 4), `DATA_WIDTH=8`.
- **Reset:** assert `rst` mid-stream with `count=3` → same cycle `count_out=0`, `empty=1`, `data_out=0`, flags 0, without a clock edge.
- **Fill and drain:**
  - Enqueue 0x11, 0x22, 0x33, 0x44 → `full=1`, `count_out=4`.
  - Dequeue 4 times → `data_out` reads 0x11, 0x22, 0x33, 0x44 on consecutive edges, then `empty=1`.
- **Overflow and underflow:**
  - 5th enqueue of 0x55 when full → `overflow=1`, `count_out=4`, 0x55 never dequeued.
  - Dequeue when empty → `underflow=1`, `data_out` holds its last value.
  - Next accepted op of the same kind clears the matching flag.
- **Wrap-around:** enqueue 3, dequeue 3, then enqueue 0xA0..0xA3 → pointers wrap, dequeues return 0xA0..0xA3 in order.
- **Simultaneous at full:**
  - Queue full with 0x11..0x44, `enq` 0x99 with `deq` → `data_out=0x11`, `count_out=4`.
  - Subsequent drain yields 0x22, 0x33, 0x44, 0x99.
- **Simultaneous at empty:** `enq` 0x77 with `deq` → `underflow=1`, `count_out=1`, `data_out` unchanged; next `deq` → `data_out=0x77`.
